hazard_control_unit: RTL

Pipeline sequencing controller for the 5-stage RV32 core. It sits beside the forwarding logic and drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX and EX/MEM. It covers three hazard sources: load-use stalls, taken-branch flushes, and freezing the pipeline around a multi-cycle EX unit (mul/div) through a start/done handshake. It also keeps a stall-cycle performance counter.

---
 rtl/hcu_pkg.sv | 42 ++++
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_control_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hcu_pkg.sv
// Shared types and constants for the hazard control unit: FSM state encoding,
// default widths and the grouped pipeline-control bundle.
package hcu_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic id_ex_bubble;
        logic if_id_flush;
        logic ex_mem_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t IDLE_CTRL = '{
        pc_write:      1'b1,
        if_id_write:   1'b1,
        id_ex_write:   1'b1,
        id_ex_bubble:  1'b0,
        if_id_flush:   1'b0,
        ex_mem_bubble: 1'b0
    };

    // Whole front end held while EX is occupied by the multi-cycle unit.
    function automatic pipe_ctrl_t freeze_ctrl();
        pipe_ctrl_t c;
        c               = IDLE_CTRL;
        c.pc_write      = 1'b0;
        c.if_id_write   = 1'b0;
        c.id_ex_write   = 1'b0;
        c.ex_mem_bubble = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Parameterised saturating up-counter with synchronous reset and clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// multi-cycle EX freeze. Optional MC watchdog enabled by HCU_MC_TIMEOUT_EN.
module hazard_control_unit
    import hcu_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MC_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [REG_ADDR_W-1:0] ARS1_ID,
    input  logic [REG_ADDR_W-1:0] ARS2_ID,
    input  logic [REG_ADDR_W-1:0] ARD_ID_EX,
    input  logic                  MEMREAD_ID_EX,
    input  logic                  BRANCH_TAKEN_EX,
    input  logic                  MC_START_ID_EX,
    input  logic                  MC_DONE,
    output logic                  PC_WRITE,
    output logic                  IF_ID_WRITE,
    output logic                  ID_EX_WRITE,
    output logic                  ID_EX_BUBBLE,
    output logic                  IF_ID_FLUSH,
    output logic                  EX_MEM_BUBBLE,
    output logic                  MC_GO,
    output logic                  MC_BUSY,
    output logic [CNT_W-1:0]      STALL_CNT,
    output logic                  MC_ERR
);

    state_t     state;
    state_t     state_nxt;
    pipe_ctrl_t ctrl;
    logic       mc_go;
    logic       mc_busy;
    logic       load_use;
    logic       timeout_hit;

    assign load_use = MEMREAD_ID_EX && (ARD_ID_EX != '0) &&
                      ((ARD_ID_EX == ARS1_ID) || (ARD_ID_EX == ARS2_ID));

    always_comb begin
        ctrl      = IDLE_CTRL;
        mc_go     = 1'b0;
        mc_busy   = 1'b0;
        state_nxt = state;
        if (!RST) begin
            case (state)
                RUN: begin
                    // A taken branch squashes the ID instruction, so its
                    // load-use dependency no longer matters.
                    if (BRANCH_TAKEN_EX) begin
                        ctrl.if_id_flush  = 1'b1;
                        ctrl.id_ex_bubble = 1'b1;
                    end else if (MC_START_ID_EX) begin
                        ctrl      = freeze_ctrl();
                        mc_go     = 1'b1;
                        state_nxt = MC_WAIT;
                    end else if (load_use) begin
                        ctrl.pc_write     = 1'b0;
                        ctrl.if_id_write  = 1'b0;
                        ctrl.id_ex_bubble = 1'b1;
                    end
                end
                MC_WAIT: begin
                    mc_busy = 1'b1;
                    if (MC_DONE || timeout_hit) begin
                        state_nxt = RUN;
                    end else begin
                        ctrl = freeze_ctrl();
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(MC_START_ID_EX && BRANCH_TAKEN_EX));
        end
    end

    assign PC_WRITE      = ctrl.pc_write;
    assign IF_ID_WRITE   = ctrl.if_id_write;
    assign ID_EX_WRITE   = ctrl.id_ex_write;
    assign ID_EX_BUBBLE  = ctrl.id_ex_bubble;
    assign IF_ID_FLUSH   = ctrl.if_id_flush;
    assign EX_MEM_BUBBLE = ctrl.ex_mem_bubble;
    assign MC_GO         = mc_go;
    assign MC_BUSY       = mc_busy;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk(CLK),
        .rst(RST),
        .clr(1'b0),
        .inc(!ctrl.pc_write),
        .q  (STALL_CNT)
    );

`ifdef HCU_MC_TIMEOUT_EN
    localparam int TO_W = $clog2(MC_TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;
    logic            mc_err_q;

    // Counts frozen MC_WAIT cycles; cleared whenever the FSM is back in RUN.
    sat_counter #(
        .W(TO_W)
    ) u_watchdog (
        .clk(CLK),
        .rst(RST),
        .clr(state != MC_WAIT),
        .inc(state == MC_WAIT),
        .q  (to_cnt)
    );

    assign timeout_hit = (state == MC_WAIT) && (to_cnt == TO_W'(MC_TIMEOUT));

    always_ff @(posedge CLK) begin
        if (RST) begin
            mc_err_q <= 1'b0;
        end else if (timeout_hit && !MC_DONE) begin
            mc_err_q <= 1'b1;
        end
    end

    assign MC_ERR = mc_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (MC_TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign MC_ERR         = 1'b0;
`endif

endmodule
